// File: rtl/nibble_compare_sequencer_if.sv
// Handshake bundle for nibble_compare_sequencer. The operand side and the result side
// each use valid/ready. The master drives operands and out_ready.
interface nibble_compare_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [3:0]       cycles;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, eq, gt, lt, cycles
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, eq, gt, lt, cycles
    );
endinterface

// File: rtl/nibble_compare_sequencer.sv
// Multi-cycle unsigned magnitude comparator. One shared 4-bit slice walks the operands
// from the most significant nibble down and stops at the first nibble that differs.
module nibble_compare_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    nibble_compare_sequencer_if.slave     bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = 4;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 60) begin : g_bad_width
            $error("nibble_compare_sequencer: WIDTH must be a multiple of 4 in 4..60");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [IDX_W-1:0]  idx;
    logic              eq_q;
    logic              gt_q;
    logic              lt_q;
    logic [3:0]        cycles_q;

    logic              in_ready;
    logic              out_valid;
    logic              accept;
    logic              consume;

    logic [WIDTH-1:0]  a_shift;
    logic [WIDTH-1:0]  b_shift;
    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic              nib_gt;
    logic              nib_lt;
    logic              last_nib;
    logic              resolved;

    // The shared 4-bit slice: pick nibble idx of each latched operand and compare.
    always_comb begin
        a_shift  = a_q >> {idx, 2'b00};
        b_shift  = b_q >> {idx, 2'b00};
        a_nib    = a_shift[3:0];
        b_nib    = b_shift[3:0];
        nib_gt   = (a_nib > b_nib);
        nib_lt   = (a_nib < b_nib);
        last_nib = (idx == '0);
        resolved = nib_gt || nib_lt || last_nib;
    end

    assign accept  = in_ready && bus.in_valid;
    assign consume = out_valid && bus.out_ready;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (resolved) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs. in_ready is also gated by rst_n so it reads 0 while reset is held.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    in_ready  = rst_n;
            COMPARE: in_ready  = 1'b0;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // NOTE: the operand registers are reset as well, so a discarded compare leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            cycles_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        idx      <= IDX_W'(NIBBLES - 1);
                        eq_q     <= 1'b0;
                        gt_q     <= 1'b0;
                        lt_q     <= 1'b0;
                        cycles_q <= '0;
                    end
                end
                COMPARE: begin
                    cycles_q <= cycles_q + 4'd1;
                    if (nib_gt) begin
                        gt_q <= 1'b1;
                    end else if (nib_lt) begin
                        lt_q <= 1'b1;
                    end else if (last_nib) begin
                        eq_q <= 1'b1;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                DONE: begin
                    // Flags drop with out_valid so they only read as set while a result is offered.
                    if (consume) begin
                        eq_q     <= 1'b0;
                        gt_q     <= 1'b0;
                        lt_q     <= 1'b0;
                        cycles_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.eq        = eq_q;
    assign bus.gt        = gt_q;
    assign bus.lt        = lt_q;
    assign bus.cycles    = cycles_q;

    // Result invariants: one-hot while offered, silent otherwise, stable under backpressure.
    property p_onehot_when_valid;
        @(posedge clk) disable iff (!rst_n)
            out_valid |-> $onehot({eq_q, gt_q, lt_q});
    endproperty
    a_onehot_when_valid: assert property (p_onehot_when_valid);

    property p_quiet_when_idle;
        @(posedge clk) disable iff (!rst_n)
            !out_valid |-> !(eq_q || gt_q || lt_q);
    endproperty
    a_quiet_when_idle: assert property (p_quiet_when_idle);

    property p_hold_under_backpressure;
        @(posedge clk) disable iff (!rst_n)
            (out_valid && !bus.out_ready) |=>
                (out_valid && $stable({eq_q, gt_q, lt_q, cycles_q}));
    endproperty
    a_hold_under_backpressure: assert property (p_hold_under_backpressure);

    property p_cycles_in_range;
        @(posedge clk) disable iff (!rst_n)
            out_valid |-> (cycles_q >= 4'd1 && 32'(cycles_q) <= NIBBLES);
    endproperty
    a_cycles_in_range: assert property (p_cycles_in_range);

endmodule

// File: tb/tb_nibble_compare_sequencer.sv
// Randomised self-checking bench: WIDTH=8 and WIDTH=16 instances checked against an
// arithmetic reference model, plus directed reset, backpressure and boundary cases.
module tb_nibble_compare_sequencer;
    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    // Per-instance stimulus and observation, index 0 = WIDTH 8, index 1 = WIDTH 16.
    logic        iv   [2];
    logic        od   [2];
    logic [63:0] a_d  [2];
    logic [63:0] b_d  [2];
    logic        ir   [2];
    logic        ov   [2];
    logic        eqv  [2];
    logic        gtv  [2];
    logic        ltv  [2];
    logic [3:0]  cyc_v[2];

    nibble_compare_sequencer_if #(.WIDTH(8))  bus8 ();
    nibble_compare_sequencer_if #(.WIDTH(16)) bus16 ();

    nibble_compare_sequencer #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    nibble_compare_sequencer #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    assign bus8.in_valid   = iv[0];
    assign bus8.out_ready  = od[0];
    assign bus8.a          = a_d[0][7:0];
    assign bus8.b          = b_d[0][7:0];
    assign ir[0]           = bus8.in_ready;
    assign ov[0]           = bus8.out_valid;
    assign eqv[0]          = bus8.eq;
    assign gtv[0]          = bus8.gt;
    assign ltv[0]          = bus8.lt;
    assign cyc_v[0]        = bus8.cycles;

    assign bus16.in_valid  = iv[1];
    assign bus16.out_ready = od[1];
    assign bus16.a         = a_d[1][15:0];
    assign bus16.b         = b_d[1][15:0];
    assign ir[1]           = bus16.in_ready;
    assign ov[1]           = bus16.out_valid;
    assign eqv[1]          = bus16.eq;
    assign gtv[1]          = bus16.gt;
    assign ltv[1]          = bus16.lt;
    assign cyc_v[1]        = bus16.cycles;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] rel(input int sel);
        return {eqv[sel], gtv[sel], ltv[sel]};
    endfunction

    // Reference: relation by plain arithmetic; nibbles examined from the top set bit of a^b.
    function automatic void model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                  output logic [2:0] exp_rel, output int exp_cyc);
        logic [63:0] diff;
        int p;
        exp_rel = {av == bv, av > bv, av < bv};
        diff = av ^ bv;
        if (diff == 64'd0) begin
            exp_cyc = w / 4;
        end else begin
            p = 63;
            while (!diff[p]) p--;
            exp_cyc = w / 4 - p / 4;
        end
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One full transaction on instance sel with garbage on ignored inputs throughout.
    task automatic txn(input int sel, input logic [63:0] av, input logic [63:0] bv,
                       input int hold, input string tag);
        int w;
        int exp_cyc;
        int k;
        logic [2:0] exp_rel;
        w = (sel == 0) ? 8 : 16;
        model(w, av, bv, exp_rel, exp_cyc);
        check({tag, ".ready"}, 64'(ir[sel]), 64'd1);
        iv[sel]  = 1'b1;
        a_d[sel] = av;
        b_d[sel] = bv;
        od[sel]  = 1'($urandom);
        @(posedge clk); #1;
        check({tag, ".busy"}, {61'd0, ir[sel], ov[sel], |rel(sel)}, 64'd0);
        k = 0;
        while (!ov[sel] && k < 20) begin
            iv[sel]  = 1'($urandom);
            a_d[sel] = rnd64();
            b_d[sel] = rnd64();
            od[sel]  = 1'($urandom);
            @(posedge clk); #1;
            k++;
        end
        check({tag, ".latency"}, 64'(k), 64'(exp_cyc));
        check({tag, ".rel"}, 64'(rel(sel)), 64'(exp_rel));
        check({tag, ".cycles"}, 64'(cyc_v[sel]), 64'(exp_cyc));
        check({tag, ".ready_done"}, 64'(ir[sel]), 64'd0);
        for (int h = 0; h < hold; h++) begin
            od[sel]  = 1'b0;
            iv[sel]  = 1'b1;
            a_d[sel] = rnd64();
            b_d[sel] = rnd64();
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 64'(ov[sel]), 64'd1);
            check({tag, ".hold_rel"}, 64'(rel(sel)), 64'(exp_rel));
            check({tag, ".hold_cycles"}, 64'(cyc_v[sel]), 64'(exp_cyc));
            check({tag, ".hold_ready"}, 64'(ir[sel]), 64'd0);
        end
        // in_valid stays high across the consume edge: it must not be taken as a new pair.
        od[sel] = 1'b1;
        iv[sel] = 1'b1;
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        od[sel] = 1'b0;
        check({tag, ".drop_valid"}, 64'(ov[sel]), 64'd0);
        check({tag, ".no_bypass"}, 64'(ir[sel]), 64'd1);
        check({tag, ".idle_rel"}, 64'(rel(sel)), 64'd0);
    endtask

    task automatic check_reset_outputs(input int sel, input string tag);
        check({tag, ".ready"}, 64'(ir[sel]), 64'd0);
        check({tag, ".valid"}, 64'(ov[sel]), 64'd0);
        check({tag, ".rel"}, 64'(rel(sel)), 64'd0);
        check({tag, ".cycles"}, 64'(cyc_v[sel]), 64'd0);
    endtask

    task automatic random_txn(input int sel);
        int w;
        int nib;
        int k;
        logic [63:0] mask;
        logic [63:0] low;
        logic [63:0] av;
        logic [63:0] bv;
        w    = (sel == 0) ? 8 : 16;
        nib  = w / 4;
        mask = (64'd1 << w) - 64'd1;
        av   = rnd64() & mask;
        case ($urandom_range(3, 0))
            0: bv = rnd64() & mask;
            1: bv = av;
            2: bv = av ^ (64'd1 << $urandom_range(w - 1, 0));
            default: begin
                k   = $urandom_range(nib - 1, 0);
                low = (64'd1 << (4 * k)) - 64'd1;
                bv  = (av & ~low) | (rnd64() & low);
            end
        endcase
        txn(sel, av, bv, ($urandom_range(7, 0) == 0) ? $urandom_range(3, 1) : 0,
            (sel == 0) ? "rnd8" : "rnd16");
    endtask

    initial begin
        int k;
        for (int s = 0; s < 2; s++) begin
            iv[s]  = 1'b0;
            od[s]  = 1'b0;
            a_d[s] = 64'd0;
            b_d[s] = 64'd0;
        end
        rst_n = 1'b0;
        #3;
        check_reset_outputs(0, "reset8");
        check_reset_outputs(1, "reset16");
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("reset8.release_ready", 64'(ir[0]), 64'd1);
        check("reset16.release_ready", 64'(ir[1]), 64'd1);

        // Directed WIDTH=8 boundary cases.
        txn(0, 64'h0F, 64'h0F, 0, "eq_15");
        txn(0, 64'hFF, 64'h00, 0, "gt_msb");
        txn(0, 64'h4A, 64'h87, 0, "lt_msb");
        txn(0, 64'h47, 64'h43, 0, "gt_lsb");
        txn(0, 64'h30, 64'h3F, 0, "lt_lsb");
        txn(0, 64'h12, 64'h12, 5, "backpressure");
        txn(1, 64'hFFFF, 64'hFFFF, 0, "eq16_max");
        txn(1, 64'h0000, 64'h0001, 0, "lt16_lsb");

        // Reset mid-COMPARE on the 16-bit instance.
        iv[1]  = 1'b1;
        a_d[1] = 64'hABCD;
        b_d[1] = 64'hABCE;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(1, "midcmp_reset16");
        check_reset_outputs(0, "midcmp_reset8");
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("midcmp_release_ready", 64'(ir[1]), 64'd1);
        txn(1, 64'hABCD, 64'hABCE, 0, "rerun16");

        // Reset while a result is held in DONE under backpressure.
        iv[0]  = 1'b1;
        a_d[0] = 64'h12;
        b_d[0] = 64'h34;
        od[0]  = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        k = 0;
        while (!ov[0] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_reset.pending", 64'(ov[0]), 64'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0, "done_reset8");
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("done_reset.release_ready", 64'(ir[0]), 64'd1);
        txn(0, 64'h9C, 64'h9C, 0, "after_reset8");

        // Random sweep, both widths in parallel.
        fork
            begin
                for (int i = 0; i < 5000; i++) random_txn(0);
            end
            begin
                for (int i = 0; i < 5000; i++) random_txn(1);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_compare_sequencer.md
Name: nibble_compare_sequencer

Overview:
- Multi-cycle magnitude comparator for WIDTH-bit unsigned operands.
- Sequences a single shared 4-bit eq/gt/lt slice across the operand nibbles, most significant nibble first, and stops at the first nibble that differs.
- Accepts operand pairs on a valid/ready input handshake and returns a one-hot eq/gt/lt result on a valid/ready output handshake.
- Replaces wide parallel compare logic where area matters more than latency.

Parameters:
- WIDTH, 8, operand width in bits. Must be a multiple of 4, range 4..60.
- NIBBLES, WIDTH/4, derived, number of 4-bit slices. Not for override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- eq  output  1  A == B.
- gt  output  1  A > B.
- lt  output  1  A < B.
- cycles  output  4  number of nibbles examined, 1..NIBBLES.

Behaviour:
- Reset: one clock, asynchronous active-low reset rst_n. While rst_n=0, all of the following hold:
  - state=IDLE, in_ready=0 until reset releases, then 1;
  - out_valid=0, eq=gt=lt=0, cycles=0;
  - internal operand registers and index cleared.
- States: IDLE, COMPARE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: latch a and b, idx=NIBBLES-1, clear eq/gt/lt/cycles, go to COMPARE.
- COMPARE:
  - in_ready=0.
  - Each cycle, compare nibble idx of the latched operands, bits [4*idx+3:4*idx], on the 4-bit slice.
  - cycles increments at every COMPARE edge.
  - Nibble A>B: gt=1, go to DONE.
  - Nibble A<B: lt=1, go to DONE.
  - Nibble equal and idx==0: eq=1, go to DONE.
  - Nibble equal and idx>0: idx decrements, stay in COMPARE.
- DONE:
  - out_valid=1, in_ready=0.
  - eq/gt/lt/cycles held stable until out_valid&out_ready at an edge, then go to IDLE.
  - out_valid drops on that same edge.
- Latency: with acceptance at edge E0, out_valid rises at edge E0+d, where d = cycles = number of nibbles examined.
  - Best case is 1 (MSB nibble differs).
  - Worst case is NIBBLES (equal operands, or difference only in nibble 0).
- Invariant: exactly one of eq/gt/lt is 1 whenever out_valid=1. All three are 0 in IDLE and COMPARE.
- No bypass: a new operand pair is never accepted in the cycle the result is consumed. Minimum issue interval is d+2 cycles.
- in_valid is ignored outside IDLE, and a/b are never sampled outside the acceptance edge. Changing a/b during COMPARE has no effect.
- out_ready outside DONE is ignored.
- Reset asserted in any state, including mid-COMPARE or DONE with out_ready=0: immediate return to the reset values above, and the pending result is discarded.
- Unsigned compare only. No X propagation from unused operand bits, because every nibble slice is within WIDTH.

Test Plan:
- WIDTH=8, a=15, b=15, out_ready=1 -> eq=1, gt=lt=0, cycles=2; out_valid rises 2 edges after acceptance, for 1 cycle.
- WIDTH=8, a=255, b=0 -> gt=1, cycles=1; a=74 (0x4A), b=135 (0x87) -> lt=1, cycles=1.
- WIDTH=8, a=0x47, b=0x43 -> gt=1, cycles=2; a=0x30, b=0x3F -> lt=1, cycles=2.
- Backpressure: a=0x12, b=0x12, out_ready=0 for 5 cycles with in_valid=1 and a/b toggling -> out_valid, eq=1 and cycles=2 held stable, in_ready=0, no new accept; out_ready=1 -> IDLE next edge, in_ready=1.
- WIDTH=16, a=0xABCD, b=0xABCE, then rst_n=0 pulse after the 2nd COMPARE edge -> all outputs 0 immediately; after release, a=0xABCD, b=0xABCE re-issued -> lt=1, cycles=4.
- Random sweep, 10k pairs, WIDTH=8 and 16 -> eq/gt/lt match a golden (a==b, a>b, a<b); cycles equals the index of the first differing nibble from the MSB plus 1, or NIBBLES if equal.
